tlc_monitor: RTL and testbench

TLC_MONITOR -- requirements
Module: tlc_monitor

---
 rtl/tlc_monitor_if.sv | 22 ++
 rtl/tlc_monitor.sv | 166 ++++++++++++++++
 tb/tb_tlc_monitor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tlc_monitor_if.sv
// Signal bundle between a traffic-light controller and its safety monitor.
// The controller side (master) drives the lamp codes and the operator
// acknowledge; the monitor side (slave) returns the latched fault status.
interface tlc_monitor_if;
    logic [1:0] highwaySignal;  // 11 green, 10 yellow, 01 red, 00 invalid
    logic [1:0] farmSignal;     // same encoding
    logic       clearFault;     // operator fault acknowledge, level-sampled
    logic       fault;          // 1 while a fault is latched
    logic [2:0] faultCode;      // first fault cause, 0 when no fault
    logic       flashRed;       // lamp-driver override, equal to fault
    logic       monState;       // 0 RUN, 1 FAULT

    modport master (
        output highwaySignal, farmSignal, clearFault,
        input  fault, faultCode, flashRed, monState
    );

    modport slave (
        input  highwaySignal, farmSignal, clearFault,
        output fault, faultCode, flashRed, monState
    );
endinterface

// File: rtl/tlc_monitor.sv
// Traffic-light safety monitor. Watches the highway/farm lamp codes,
// measures how long each lamp pair is held, and latches the first fault
// seen (conflict, invalid code, illegal step, short yellow, short all-red
// clearance) until the operator acknowledges it with both roads red.
// Optional feature: define TLC_MON_MAXGREEN_EN to add fault code 6,
// farm green held longer than FARM_GREEN_MAX cycles.
module tlc_monitor #(
    parameter int YELLOW_MIN     = 150000000,
    parameter int ALLRED_MIN     = 50000000,
    parameter int FARM_GREEN_MAX = 900000000
) (
    input  logic         Clk,
    input  logic         Rst,
    tlc_monitor_if.slave mon
);

    localparam logic [1:0] LAMP_GREEN   = 2'b11;
    localparam logic [1:0] LAMP_YELLOW  = 2'b10;
    localparam logic [1:0] LAMP_RED     = 2'b01;
    localparam logic [1:0] LAMP_INVALID = 2'b00;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    localparam logic [30:0] DWELL_MAX    = {31{1'b1}};
    localparam logic [30:0] YELLOW_MIN_W = 31'(YELLOW_MIN);
    localparam logic [30:0] ALLRED_MIN_W = 31'(ALLRED_MIN);

    // Thresholds must fit the 31-bit dwell counter.
    if (YELLOW_MIN < 1 || ALLRED_MIN < 1 ||
        FARM_GREEN_MAX < 1 || FARM_GREEN_MAX > 2147483646) begin : g_param_check
        $error("tlc_monitor: timing parameter out of range");
    end

    // A lamp stepping backwards through its cycle.
    function automatic logic bad_step(input logic [1:0] from, input logic [1:0] to);
        return (from == LAMP_GREEN  && to == LAMP_RED)    ||
               (from == LAMP_RED    && to == LAMP_YELLOW) ||
               (from == LAMP_YELLOW && to == LAMP_GREEN);
    endfunction

    function automatic logic is_lit(input logic [1:0] lamp);
        return lamp == LAMP_GREEN || lamp == LAMP_YELLOW;
    endfunction

    logic [1:0]  r_prev_hwy;
    logic [1:0]  r_prev_farm;
    logic [30:0] r_dwell;
    logic [0:0]  r_state;
    logic [2:0]  r_code;

    logic [1:0]  w_hwy;
    logic [1:0]  w_farm;
    logic        w_change;
    logic        w_conflict;
    logic        w_invalid;
    logic        w_sequence;
    logic        w_short_yellow;
    logic        w_short_clear;
    logic        w_overrun;
    logic [2:0]  w_code;
    logic        w_clear_ok;

    assign w_hwy  = mon.highwaySignal;
    assign w_farm = mon.farmSignal;

    // Per-cycle rule checks; r_dwell on a change cycle is how long prev was held.
    assign w_change       = {w_hwy, w_farm} != {r_prev_hwy, r_prev_farm};
    assign w_conflict     = is_lit(w_hwy) && is_lit(w_farm);
    assign w_invalid      = (w_hwy == LAMP_INVALID) || (w_farm == LAMP_INVALID);
    assign w_sequence     = w_change &&
                            (bad_step(r_prev_hwy, w_hwy) || bad_step(r_prev_farm, w_farm));
    assign w_short_yellow = w_change && (r_dwell < YELLOW_MIN_W) &&
                            ((r_prev_hwy  == LAMP_YELLOW && w_hwy  != LAMP_YELLOW) ||
                             (r_prev_farm == LAMP_YELLOW && w_farm != LAMP_YELLOW));
    assign w_short_clear  = w_change && (r_dwell < ALLRED_MIN_W) &&
                            r_prev_hwy == LAMP_RED && r_prev_farm == LAMP_RED &&
                            (w_hwy == LAMP_GREEN || w_farm == LAMP_GREEN);

`ifdef TLC_MON_MAXGREEN_EN
    localparam logic [30:0] FARM_GREEN_LIMIT = 31'(FARM_GREEN_MAX + 1);

    logic [30:0] r_farm_green;
    logic [30:0] w_farm_green_now;

    // Consecutive farm-green samples, including the current one.
    always_comb begin
        // NOTE: default first so no path leaves the signal unassigned (no latch).
        w_farm_green_now = '0;
        if (w_farm == LAMP_GREEN) begin
            w_farm_green_now = (r_farm_green == DWELL_MAX) ? DWELL_MAX
                                                           : r_farm_green + 31'd1;
        end
    end

    assign w_overrun = (w_farm_green_now == FARM_GREEN_LIMIT);

    // Farm green run length carried to the next cycle.
    always_ff @(posedge Clk) begin
        if (Rst) r_farm_green <= '0;
        else     r_farm_green <= w_farm_green_now;
    end
`else
    assign w_overrun = 1'b0;
`endif

    // Lowest-numbered active cause wins.
    always_comb begin
        w_code = 3'd0;
        if      (w_conflict)     w_code = 3'd1;
        else if (w_invalid)      w_code = 3'd2;
        else if (w_sequence)     w_code = 3'd3;
        else if (w_short_yellow) w_code = 3'd4;
        else if (w_short_clear)  w_code = 3'd5;
        else if (w_overrun)      w_code = 3'd6;
    end

    // Acknowledge only counts with both roads red and nothing wrong this cycle.
    assign w_clear_ok = (r_state == ST_FAULT) && mon.clearFault &&
                        w_hwy == LAMP_RED && w_farm == LAMP_RED && (w_code == 3'd0);

    // Previous pair and its hold time; a clear restarts the all-red measurement.
    always_ff @(posedge Clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch, and
        // all state uses non-blocking assignments so every register sees old values.
        if (Rst) begin
            r_prev_hwy  <= LAMP_RED;
            r_prev_farm <= LAMP_RED;
            r_dwell     <= '0;
        end else begin
            r_prev_hwy  <= w_hwy;
            r_prev_farm <= w_farm;
            if (w_change || w_clear_ok) r_dwell <= 31'd1;
            else if (r_dwell != DWELL_MAX) r_dwell <= r_dwell + 31'd1;
        end
    end

    // RUN/FAULT state; the first cause is held until a valid clear.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_RUN;
            r_code  <= 3'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_code != 3'd0) begin
                        r_state <= ST_FAULT;
                        r_code  <= w_code;
                    end
                end
                default: begin
                    if (w_clear_ok) begin
                        r_state <= ST_RUN;
                        r_code  <= 3'd0;
                    end
                end
            endcase
        end
    end

    assign mon.fault     = r_state;
    assign mon.flashRed  = r_state;
    assign mon.monState  = r_state;
    assign mon.faultCode = r_code;

endmodule

// File: tb/tb_tlc_monitor.sv
// Self-checking bench for tlc_monitor with short timing parameters.
// Build with TLC_MON_MAXGREEN_EN defined to cover the farm green overrun.
module tb_tlc_monitor;

    localparam int YMIN  = 6;
    localparam int AMIN  = 2;
    localparam int FGMAX = 36;

    localparam bit [1:0] GRN = 2'b11;
    localparam bit [1:0] YEL = 2'b10;
    localparam bit [1:0] RED = 2'b01;
    localparam bit [1:0] INV = 2'b00;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    always #5 Clk = ~Clk;

    tlc_monitor_if bus ();

    tlc_monitor #(
        .YELLOW_MIN     (YMIN),
        .ALLRED_MIN     (AMIN),
        .FARM_GREEN_MAX (FGMAX)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .mon (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: lamp pair last seen, how long it has been held,
    // farm green run length, and the latched fault.
    bit [1:0] m_ph, m_pf;
    int       m_held;
    int       m_fg;
    bit       m_fault;
    int       m_code;

    function automatic bit backwards(input bit [1:0] a, input bit [1:0] b);
        return (a == GRN && b == RED) || (a == RED && b == YEL) || (a == YEL && b == GRN);
    endfunction

    // Every rule broken by the current pair; the lowest-numbered one is reported.
    function automatic int lowest_violation(input bit [1:0] h, input bit [1:0] f, input bit changed);
        bit [6:1] viol;
        viol = '0;
        viol[1] = (h[1] && f[1]);
        viol[2] = (h == INV || f == INV);
        viol[3] = changed && (backwards(m_ph, h) || backwards(m_pf, f));
        viol[4] = changed && m_held < YMIN &&
                  ((m_ph == YEL && h != YEL) || (m_pf == YEL && f != YEL));
        viol[5] = changed && m_held < AMIN && m_ph == RED && m_pf == RED &&
                  (h == GRN || f == GRN);
`ifdef TLC_MON_MAXGREEN_EN
        viol[6] = (m_fg == FGMAX + 1);
`endif
        for (int i = 1; i <= 6; i++) if (viol[i]) return i;
        return 0;
    endfunction

    task automatic model_update(input bit rst, input bit [1:0] h, input bit [1:0] f, input bit clr);
        bit changed;
        bit cleared;
        int code;
        if (rst) begin
            m_ph = RED; m_pf = RED; m_held = 0; m_fg = 0; m_fault = 0; m_code = 0;
            return;
        end
        changed = ({h, f} != {m_ph, m_pf});
        cleared = 0;
        m_fg    = (f == GRN) ? m_fg + 1 : 0;
        code    = lowest_violation(h, f, changed);
        if (m_fault) begin
            if (clr && h == RED && f == RED && code == 0) begin
                m_fault = 0; m_code = 0; cleared = 1;
            end
        end else if (code != 0) begin
            m_fault = 1; m_code = code;
        end
        m_held = (changed || cleared) ? 1 : m_held + 1;
        m_ph = h;
        m_pf = f;
    endtask

    // One clock: drive inputs, let the edge happen, compare against the model.
    task automatic step(input bit rst, input bit [1:0] h, input bit [1:0] f, input bit clr);
        Rst = rst;
        bus.highwaySignal = h;
        bus.farmSignal    = f;
        bus.clearFault    = clr;
        @(posedge Clk);
        #1;
        model_update(rst, h, f, clr);
        checks++;
        if (bus.fault !== m_fault || bus.flashRed !== m_fault ||
            bus.monState !== m_fault || bus.faultCode !== 3'(m_code)) begin
            errors++;
            $display("FAIL model t=%0t in=%b/%b clr=%0b: fault=%b flash=%b state=%b code=%0d, expected fault=%0b code=%0d",
                     $time, h, f, clr, bus.fault, bus.flashRed, bus.monState, bus.faultCode, m_fault, m_code);
        end
    endtask

    task automatic hold(input bit [1:0] h, input bit [1:0] f, input int n, input bit clr);
        for (int i = 0; i < n; i++) step(0, h, f, clr);
    endtask

    task automatic go_run(input int red_cycles);
        step(1, RED, RED, 0);
        hold(RED, RED, red_cycles, 0);
    endtask

    task automatic expect_status(input string name, input bit exp_fault, input bit [2:0] exp_code);
        checks++;
        if (bus.fault !== exp_fault || bus.flashRed !== exp_fault ||
            bus.monState !== exp_fault || bus.faultCode !== exp_code) begin
            errors++;
            $display("FAIL %s: fault=%b flash=%b state=%b code=%0d, expected fault=%0b code=%0d",
                     name, bus.fault, bus.flashRed, bus.monState, bus.faultCode, exp_fault, exp_code);
        end
    endtask

    task automatic test_reset();
        step(1, GRN, GRN, 1);
        step(1, RED, RED, 1);
        expect_status("reset_state", 0, 3'd0);
        // First all-red interval counts from reset: one cycle is too short.
        step(0, RED, RED, 0);
        step(0, GRN, RED, 0);
        expect_status("first_clearance_short", 1, 3'd5);
        step(1, RED, RED, 1);
        expect_status("reset_in_fault", 0, 3'd0);
    endtask

    task automatic test_legal_cycle();
        step(1, RED, RED, 0);
        hold(RED, RED, 2, 0);
        hold(GRN, RED, 10, 0);
        hold(YEL, RED, 6, 0);
        hold(RED, RED, 2, 0);
        hold(RED, GRN, 8, 0);
        hold(RED, YEL, 6, 0);
        hold(RED, RED, 3, 0);
        expect_status("legal_cycle", 0, 3'd0);
    endtask

    task automatic test_conflict();
        step(0, GRN, GRN, 0);
        expect_status("conflict", 1, 3'd1);
    endtask

    task automatic test_clear();
        step(0, GRN, RED, 1);
        expect_status("clear_with_green", 1, 3'd1);
        hold(YEL, RED, 3, 0);
        step(0, RED, RED, 1);
        expect_status("clear_with_fault_cond", 1, 3'd1);
        step(0, RED, RED, 1);
        expect_status("clear_ok", 0, 3'd0);
        // Dwell restarted at 1, so green on the very next cycle is a short clearance.
        step(0, GRN, RED, 0);
        expect_status("dwell_after_clear", 1, 3'd5);
        step(0, GRN, RED, 1);
        expect_status("clear_ignored_nonred", 1, 3'd5);
    endtask

    task automatic test_short_yellow();
        go_run(3);
        hold(GRN, RED, 10, 0);
        hold(YEL, RED, 5, 0);
        step(0, RED, RED, 0);
        expect_status("short_yellow", 1, 3'd4);
        step(0, RED, INV, 0);
        expect_status("code_kept_in_fault", 1, 3'd4);
    endtask

    task automatic test_priority();
        go_run(3);
        hold(GRN, RED, 10, 0);
        step(0, RED, INV, 0);
        expect_status("invalid_over_sequence", 1, 3'd2);
        go_run(3);
        hold(GRN, RED, 10, 0);
        step(0, RED, RED, 0);
        expect_status("sequence_green_red", 1, 3'd3);
        go_run(3);
        step(0, RED, RED, 1);
        expect_status("clear_ignored_in_run", 0, 3'd0);
    endtask

    task automatic test_max_green();
        go_run(3);
        hold(RED, GRN, FGMAX, 0);
        expect_status("farm_green_at_max", 0, 3'd0);
        step(0, RED, GRN, 0);
`ifdef TLC_MON_MAXGREEN_EN
        expect_status("farm_green_overrun", 1, 3'd6);
`else
        expect_status("farm_green_no_overrun", 0, 3'd0);
`endif
        hold(RED, GRN, 4, 0);
    endtask

    task automatic test_random();
        bit [1:0] pool [5];
        bit [1:0] h, f;
        int dur;
        pool[0] = RED; pool[1] = GRN; pool[2] = YEL; pool[3] = RED; pool[4] = INV;
        go_run(3);
        for (int seg = 0; seg < 70; seg++) begin
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0:       begin h = RED; f = RED; end
                    1:       begin h = GRN; f = RED; end
                    2:       begin h = YEL; f = RED; end
                    3:       begin h = RED; f = GRN; end
                    default: begin h = RED; f = YEL; end
                endcase
            end else begin
                h = pool[$urandom_range(0, 4)];
                f = pool[$urandom_range(0, 4)];
            end
            dur = ($urandom_range(0, 19) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 8);
            for (int k = 0; k < dur; k++)
                step($urandom_range(0, 99) == 0, h, f, $urandom_range(0, 9) < 3);
        end
    endtask

    initial begin
        bus.highwaySignal = RED;
        bus.farmSignal    = RED;
        bus.clearFault    = 1'b0;
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_clear();
        test_short_yellow();
        test_priority();
        test_max_green();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
